// File: rtl/cachefill_pkg.sv
// Shared types for the cache fill sequencer: FSM state encoding and default line geometry.
package cachefill_pkg;

  localparam int unsigned BEATS_DEFAULT = 4;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_WB,
    ST_FILL,
    ST_INSTALL
  } fill_state_e;

endpackage

// File: rtl/cache_fill_seq_if.sv
// Miss/victim inputs and bus/array-control outputs of the cache fill sequencer.
// master = sequencer side, slave = pipeline/bus side.
interface cache_fill_seq_if
  import cachefill_pkg::*;
#(
  parameter int unsigned NUMWAYS = 4,
  parameter int unsigned BEATS   = BEATS_DEFAULT
);
  localparam int unsigned BEATLEN = $clog2(BEATS);

  logic               Miss;
  logic               FlushStage;
  logic [NUMWAYS-1:0] VictimWay;
  logic               VictimDirty;
  logic               BusAck;

  logic               BusReq;
  logic               BusWrite;
  logic [BEATLEN-1:0] BeatCount;
  logic [NUMWAYS-1:0] FillWay;
  logic               BeatWriteEn;
  logic               SetValid;
  logic               ClearDirty;
  logic               LRUWriteEn;
  logic               Stall;

  modport master (
    input  Miss, FlushStage, VictimWay, VictimDirty, BusAck,
    output BusReq, BusWrite, BeatCount, FillWay, BeatWriteEn,
           SetValid, ClearDirty, LRUWriteEn, Stall
  );

  modport slave (
    output Miss, FlushStage, VictimWay, VictimDirty, BusAck,
    input  BusReq, BusWrite, BeatCount, FillWay, BeatWriteEn,
           SetValid, ClearDirty, LRUWriteEn, Stall
  );

endinterface

// File: rtl/cache_fill_seq_beatcounter.sv
// Beat index counter for one cache line; wraps naturally at BEATS-1 (BEATS is a power of two).
module beatcounter #(
  parameter int unsigned BEATLEN = 2
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               clear_i,
  input  logic               en_i,
  output logic [BEATLEN-1:0] count_o,
  output logic               wrap_o
);
  logic [BEATLEN-1:0] count_q, count_d;

  always_comb begin
    count_d = count_q;
    if (clear_i) begin
      count_d = '0;
    end else if (en_i) begin
      count_d = count_q + BEATLEN'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count_o = count_q;
  // Last beat of the line is being accepted this cycle.
  assign wrap_o  = en_i & (&count_q);

endmodule

// File: rtl/cache_fill_seq.sv
// Cache line allocation sequencer: optional dirty-victim writeback, line fill, install strobes.
// Writeback path (WB state, VictimDirty, BusWrite, ClearDirty) exists only with CACHE_FILL_WRITEBACK_EN.
module cache_fill_seq
  import cachefill_pkg::*;
#(
  parameter int unsigned NUMWAYS = 4,
  parameter int unsigned BEATS   = BEATS_DEFAULT
) (
  input logic              clk,
  input logic              reset,
  cache_fill_seq_if.master bus
);
  localparam int unsigned BEATLEN = $clog2(BEATS);

`ifdef CACHE_FILL_WRITEBACK_EN
  localparam bit WB_EN = 1'b1;
`else
  localparam bit WB_EN = 1'b0;
`endif

  fill_state_e        state_q, state_d;
  logic [NUMWAYS-1:0] fill_way_q, fill_way_d;
  logic               start, beat_en, last_beat, cnt_clear;
  logic [BEATLEN-1:0] beat_cnt;
  logic               bus_req, bus_write, beat_we;
  logic               set_valid, clear_dirty, lru_we;

  assign start     = bus.Miss & ~bus.FlushStage;
  assign cnt_clear = (state_q == ST_IDLE);

  beatcounter #(.BEATLEN(BEATLEN)) u_beatcounter (
    .clk     (clk),
    .reset   (reset),
    .clear_i (cnt_clear),
    .en_i    (beat_en),
    .count_o (beat_cnt),
    .wrap_o  (last_beat)
  );

  always_comb begin
    state_d     = state_q;
    fill_way_d  = fill_way_q;
    beat_en     = 1'b0;
    bus_req     = 1'b0;
    bus_write   = 1'b0;
    beat_we     = 1'b0;
    set_valid   = 1'b0;
    clear_dirty = 1'b0;
    lru_we      = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (start) begin
          fill_way_d = bus.VictimWay;
          state_d    = (WB_EN && bus.VictimDirty) ? ST_WB : ST_FILL;
        end
      end
      ST_WB: begin
        bus_req   = 1'b1;
        bus_write = WB_EN;
        beat_en   = bus.BusAck;
        if (last_beat) state_d = ST_FILL;
      end
      ST_FILL: begin
        bus_req = 1'b1;
        beat_en = bus.BusAck;
        beat_we = bus.BusAck;
        if (last_beat) state_d = ST_INSTALL;
      end
      ST_INSTALL: begin
        set_valid   = 1'b1;
        clear_dirty = WB_EN;
        lru_we      = 1'b1;
        fill_way_d  = '0;
        state_d     = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= ST_IDLE;
      fill_way_q <= '0;
    end else begin
      state_q    <= state_d;
      fill_way_q <= fill_way_d;
    end
  end

  assign bus.BusReq      = bus_req;
  assign bus.BusWrite    = bus_write;
  assign bus.BeatCount   = beat_cnt;
  assign bus.FillWay     = fill_way_q;
  assign bus.BeatWriteEn = beat_we;
  assign bus.SetValid    = set_valid;
  assign bus.ClearDirty  = clear_dirty;
  assign bus.LRUWriteEn  = lru_we;
  assign bus.Stall       = (state_q != ST_IDLE) | start;

  // The replacement policy must hand over exactly one way when an allocation starts.
  assert property (@(posedge clk) disable iff (reset)
    (state_q == ST_IDLE && start) |-> $onehot(bus.VictimWay));

endmodule

// File: tb/tb_cache_fill_seq.sv
// Bench for cache_fill_seq: queue-based allocation model checked every cycle, directed
// literal scenarios, then randomized traffic. Honours CACHE_FILL_WRITEBACK_EN like the DUT.
module tb_cache_fill_seq;
  localparam int NW  = 4;
  localparam int NB  = 4;
  localparam int NBL = $clog2(NB);

`ifdef CACHE_FILL_WRITEBACK_EN
  localparam bit WB_EN = 1'b1;
`else
  localparam bit WB_EN = 1'b0;
`endif

  logic clk;
  logic reset;

  cache_fill_seq_if #(.NUMWAYS(NW), .BEATS(NB)) ifc ();

  cache_fill_seq #(.NUMWAYS(NW), .BEATS(NB)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (ifc.master)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  // Model: an allocation is a queue of steps (writeback beats, fill beats, install).
  typedef struct packed {
    logic           install;
    logic           wr;
    logic [NBL-1:0] idx;
  } step_t;

  step_t         mq[$];
  logic [NW-1:0] m_way;
  bit            m_valid = 1'b0;

  always @(posedge clk) begin
    if (reset) begin
      mq.delete();
      m_way   = '0;
      m_valid = 1'b1;
    end else if (m_valid) begin
      if (mq.size() == 0) begin
        if (ifc.Miss && !ifc.FlushStage) begin
          m_way = ifc.VictimWay;
          if (ifc.VictimDirty && WB_EN)
            for (int i = 0; i < NB; i++) mq.push_back('{install: 1'b0, wr: 1'b1, idx: NBL'(i)});
          for (int i = 0; i < NB; i++) mq.push_back('{install: 1'b0, wr: 1'b0, idx: NBL'(i)});
          mq.push_back('{install: 1'b1, wr: 1'b0, idx: '0});
        end
      end else if (mq[0].install || ifc.BusAck) begin
        void'(mq.pop_front());
        if (mq.size() == 0) m_way = '0;
      end
    end
  end

  always @(negedge clk) begin
    if (m_valid) begin
      logic e_req, e_wr, e_we, e_inst, e_stall;
      logic [NBL-1:0] e_cnt;
      e_req = 1'b0; e_wr = 1'b0; e_we = 1'b0; e_inst = 1'b0; e_cnt = '0;
      if (mq.size() == 0) begin
        e_stall = ifc.Miss & ~ifc.FlushStage;
      end else begin
        e_stall = 1'b1;
        if (mq[0].install) begin
          e_inst = 1'b1;
        end else begin
          e_req = 1'b1;
          e_wr  = mq[0].wr;
          e_cnt = mq[0].idx;
          e_we  = ~mq[0].wr & ifc.BusAck;
        end
      end
      chk("m_busreq", 32'(ifc.BusReq), 32'(e_req));
      chk("m_buswrite", 32'(ifc.BusWrite), 32'(e_wr));
      chk("m_beatcount", 32'(ifc.BeatCount), 32'(e_cnt));
      chk("m_fillway", 32'(ifc.FillWay), 32'(m_way));
      chk("m_beatwe", 32'(ifc.BeatWriteEn), 32'(e_we));
      chk("m_setvalid", 32'(ifc.SetValid), 32'(e_inst));
      chk("m_cleardirty", 32'(ifc.ClearDirty), 32'(e_inst & WB_EN));
      chk("m_lruwe", 32'(ifc.LRUWriteEn), 32'(e_inst));
      chk("m_stall", 32'(ifc.Stall), 32'(e_stall));
    end
  end

  // Full allocation with BusAck held high; literal per-cycle expectations.
  task automatic run_alloc(input logic [NW-1:0] way, input logic dirty);
    int nwb;
    nwb = (dirty && WB_EN) ? NB : 0;
    ifc.Miss = 1'b1; ifc.VictimWay = way; ifc.VictimDirty = dirty; ifc.BusAck = 1'b1;
    @(negedge clk);
    chk("start_stall", 32'(ifc.Stall), 32'd1);
    chk("start_busreq", 32'(ifc.BusReq), 32'd0);
    cyc();
    ifc.Miss = 1'b0;
    for (int i = 0; i < nwb + NB; i++) begin
      @(negedge clk);
      chk("beat_busreq", 32'(ifc.BusReq), 32'd1);
      chk("beat_buswrite", 32'(ifc.BusWrite), (i < nwb) ? 32'd1 : 32'd0);
      chk("beat_count", 32'(ifc.BeatCount), 32'(i % NB));
      chk("beat_fillway", 32'(ifc.FillWay), 32'(way));
      chk("beat_we", 32'(ifc.BeatWriteEn), (i >= nwb) ? 32'd1 : 32'd0);
      cyc();
    end
    @(negedge clk);
    chk("inst_setvalid", 32'(ifc.SetValid), 32'd1);
    chk("inst_lru", 32'(ifc.LRUWriteEn), 32'd1);
    chk("inst_cleardirty", 32'(ifc.ClearDirty), 32'(WB_EN));
    chk("inst_busreq", 32'(ifc.BusReq), 32'd0);
    cyc();
    @(negedge clk);
    chk("done_busreq", 32'(ifc.BusReq), 32'd0);
    chk("done_setvalid", 32'(ifc.SetValid), 32'd0);
    chk("done_stall", 32'(ifc.Stall), 32'd0);
    chk("done_fillway", 32'(ifc.FillWay), 32'd0);
    cyc();
  endtask

  initial begin
    reset = 1'b1;
    ifc.Miss = 1'b0; ifc.FlushStage = 1'b0; ifc.VictimWay = 4'b0001;
    ifc.VictimDirty = 1'b0; ifc.BusAck = 1'b0;
    repeat (2) cyc();
    reset = 1'b0;
    @(negedge clk);
    chk("rst_busreq", 32'(ifc.BusReq), 32'd0);
    chk("rst_beatcount", 32'(ifc.BeatCount), 32'd0);
    chk("rst_fillway", 32'(ifc.FillWay), 32'd0);
    chk("rst_stall", 32'(ifc.Stall), 32'd0);
    cyc();

    run_alloc(4'b0100, 1'b0);
    run_alloc(4'b0010, 1'b1);

    // BusAck withheld for three cycles on fill beat 2
    ifc.Miss = 1'b1; ifc.VictimWay = 4'b1000; ifc.VictimDirty = 1'b0; ifc.BusAck = 1'b1;
    cyc();
    ifc.Miss = 1'b0;
    repeat (2) cyc();
    ifc.BusAck = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("hold_count", 32'(ifc.BeatCount), 32'd2);
      chk("hold_busreq", 32'(ifc.BusReq), 32'd1);
      chk("hold_we", 32'(ifc.BeatWriteEn), 32'd0);
      cyc();
    end
    ifc.BusAck = 1'b1;
    @(negedge clk);
    chk("resume_count", 32'(ifc.BeatCount), 32'd2);
    chk("resume_we", 32'(ifc.BeatWriteEn), 32'd1);
    cyc();
    @(negedge clk);
    chk("resume_last", 32'(ifc.BeatCount), 32'd3);
    cyc();
    @(negedge clk);
    chk("resume_setvalid", 32'(ifc.SetValid), 32'd1);
    cyc();

    // Flush blocks a start in IDLE but not a running sequence
    ifc.Miss = 1'b1; ifc.FlushStage = 1'b1; ifc.VictimWay = 4'b0001; ifc.BusAck = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("flush_idle_busreq", 32'(ifc.BusReq), 32'd0);
      chk("flush_idle_stall", 32'(ifc.Stall), 32'd0);
      cyc();
    end
    ifc.FlushStage = 1'b0;
    cyc();
    ifc.FlushStage = 1'b1;
    for (int i = 0; i < NB; i++) begin
      @(negedge clk);
      chk("flush_run_count", 32'(ifc.BeatCount), 32'(i));
      chk("flush_run_busreq", 32'(ifc.BusReq), 32'd1);
      chk("flush_run_way", 32'(ifc.FillWay), 32'd1);
      cyc();
    end
    @(negedge clk);
    chk("flush_setvalid", 32'(ifc.SetValid), 32'd1);
    cyc();
    @(negedge clk);
    chk("flush_after_busreq", 32'(ifc.BusReq), 32'd0);
    chk("flush_after_stall", 32'(ifc.Stall), 32'd0);
    ifc.Miss = 1'b0; ifc.FlushStage = 1'b0;
    cyc();

    // Reset during fill beat 1
    ifc.Miss = 1'b1; ifc.VictimWay = 4'b0010; ifc.VictimDirty = 1'b0; ifc.BusAck = 1'b1;
    cyc();
    ifc.Miss = 1'b0;
    cyc();
    reset = 1'b1;
    @(negedge clk);
    chk("pre_rst_count", 32'(ifc.BeatCount), 32'd1);
    cyc();
    reset = 1'b0;
    @(negedge clk);
    chk("mid_rst_busreq", 32'(ifc.BusReq), 32'd0);
    chk("mid_rst_count", 32'(ifc.BeatCount), 32'd0);
    chk("mid_rst_fillway", 32'(ifc.FillWay), 32'd0);
    chk("mid_rst_setvalid", 32'(ifc.SetValid), 32'd0);
    chk("mid_rst_stall", 32'(ifc.Stall), 32'd0);
    cyc();

    // Randomized traffic, checked by the model every cycle
    for (int c = 0; c < 3000; c++) begin
      ifc.Miss        = ($urandom_range(0, 99) < 35);
      ifc.FlushStage  = ($urandom_range(0, 99) < 20);
      ifc.VictimWay   = NW'(1) << $urandom_range(0, NW - 1);
      ifc.VictimDirty = 1'($urandom_range(0, 1));
      ifc.BusAck      = ($urandom_range(0, 99) < 70);
      reset           = ($urandom_range(0, 999) < 5);
      cyc();
    end
    reset = 1'b0; ifc.Miss = 1'b0;
    repeat (2) cyc();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
